// File: rtl/fifo_pkg.sv
// Shared constants and width helpers for the dual-clock FIFO and its read-side packer.
package fifo_pkg;

  localparam int FIFO_DSIZE = 8;
  localparam int FIFO_ASIZE = 4;

  function automatic int cntWidth(input int pack);
    return $clog2(pack + 1);
  endfunction

  function automatic int laneWidth(input int pack);
    return (pack > 1) ? $clog2(pack) : 1;
  endfunction

  function automatic int idleWidth(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/pack_idle_timer.sv
// Saturating idle counter used to flush partial packed words.
// Only instantiated when FIFO_PACK_FLUSH_EN is defined.
module pack_idle_timer
  import fifo_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  output logic o_expired
);

  localparam int TW = idleWidth(TIMEOUT);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT);

  logic [TW-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_count <= '0;
    end else if (r_count != T_MAX) begin
      r_count <= r_count + TW'(1);
    end
  end

  assign o_expired = (r_count == T_MAX);

endmodule

// File: rtl/fifo_rd_packer.sv
// Read-side FIFO consumer: pops entries and packs PACK of them per valid/ready output word.
// Define FIFO_PACK_FLUSH_EN to flush partial words after TIMEOUT idle cycles.
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int DSIZE      = FIFO_DSIZE,
  parameter int PACK       = 4,
  parameter int BIG_ENDIAN = 0,
  parameter int TIMEOUT    = 16
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic [DSIZE-1:0]      rdata,
  input  logic                  rempty,
  output logic                  rinc,
  output logic [DSIZE*PACK-1:0] m_data,
  output logic [PACK-1:0]       m_keep,
  output logic                  m_valid,
  input  logic                  m_ready
);

  localparam int CW = cntWidth(PACK);
  localparam int LW = laneWidth(PACK);
  localparam logic [CW-1:0] CNT_FULL = CW'(PACK);
  localparam logic [CW-1:0] CNT_LAST = CW'(PACK - 1);

  if (PACK < 2 || TIMEOUT < 1) begin : g_badParams
    $error("fifo_rd_packer: PACK must be >= 2 and TIMEOUT >= 1");
  end

  logic [DSIZE-1:0]      r_acc [PACK];
  logic [CW-1:0]         r_cnt;
  logic [DSIZE*PACK-1:0] r_data;
  logic [PACK-1:0]       r_keep;
  logic                  r_valid;

  logic                  w_outFree;
  logic                  w_complete;
  logic                  w_flush;
  logic [LW-1:0]         w_lane;
  logic [DSIZE*PACK-1:0] w_word;
  logic [PACK-1:0]       w_flushKeep;

  assign rinc       = !rrst && !rempty && (r_cnt < CNT_FULL);
  assign w_outFree  = !r_valid || m_ready;
  assign w_complete = (r_cnt == CNT_FULL) || ((r_cnt == CNT_LAST) && rinc);

  // The word being loaded includes the entry popped this very cycle.
  always_comb begin
    w_lane = LW'((BIG_ENDIAN != 0) ? (PACK - 1 - int'(r_cnt)) : int'(r_cnt));
    w_word = '0;
    for (int i = 0; i < PACK; i++) begin
      w_word[i*DSIZE +: DSIZE] = (rinc && (w_lane == LW'(i))) ? rdata : r_acc[i];
    end
  end

`ifdef FIFO_PACK_FLUSH_EN
  logic w_idleExpired;

  pack_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idleTimer (
    .i_clk     (rclk),
    .i_rst     (rrst),
    .i_clear   (rinc || (r_cnt == '0)),
    .o_expired (w_idleExpired)
  );

  // A pop in the same cycle wins over the flush.
  assign w_flush = w_idleExpired && (r_cnt != '0) && (r_cnt < CNT_FULL) && w_outFree && !rinc;

  always_comb begin
    w_flushKeep = '0;
    for (int i = 0; i < PACK; i++) begin
      w_flushKeep[i] = (BIG_ENDIAN != 0) ? (i >= PACK - int'(r_cnt)) : (i < int'(r_cnt));
    end
  end
`else
  assign w_flush     = 1'b0;
  assign w_flushKeep = '1;
`endif

  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_cnt   <= '0;
      r_data  <= '0;
      r_keep  <= '0;
      r_valid <= 1'b0;
      for (int i = 0; i < PACK; i++) r_acc[i] <= '0;
    end else if ((w_complete || w_flush) && w_outFree) begin
      r_data  <= w_word;
      r_keep  <= w_complete ? '1 : w_flushKeep;
      r_valid <= 1'b1;
      r_cnt   <= '0;
      for (int i = 0; i < PACK; i++) r_acc[i] <= '0;
    end else begin
      if (r_valid && m_ready) r_valid <= 1'b0;
      if (rinc) begin
        r_cnt         <= r_cnt + CW'(1);
        r_acc[w_lane] <= rdata;
      end
    end
  end

  assign m_data  = r_data;
  assign m_keep  = r_keep;
  assign m_valid = r_valid;

endmodule
